// File: rtl/carpark_pkg.sv
// Shared types, default sizing and helpers for the two-gate car park access controller.
package carpark_pkg;

    typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} gate_state_t;

    localparam int NUM_GATES    = 2;
    localparam int CAPACITY_DEF = 7;
    localparam int CNT_W_DEF    = 3;
    localparam int TIMEOUT_DEF  = 50;
    localparam int TO_W_DEF     = 6;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/carpark_access_ctrl_if.sv
// Gate-side bundle: requests and sensor pulses in, barrier/occupancy status out.
interface carpark_access_ctrl_if #(
    parameter int CNT_W = carpark_pkg::CNT_W_DEF
);
    logic [1:0]       req;
    logic [1:0]       enter;
    logic [1:0]       exit;
    logic [1:0]       gate_open;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             err;

    modport master (
        output req, enter, exit,
        input  gate_open, count, full, err
    );

    modport slave (
        input  req, enter, exit,
        output gate_open, count, full, err
    );
endinterface

// File: rtl/gate_sequencer.sv
// Per-gate barrier FSM: opens on grant, closes on entry or after TIMEOUT open cycles.
module gate_sequencer
    import carpark_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic grant,
    input  logic enter_i,
    output logic is_open
);

    gate_state_t     state, state_next;
    logic [TO_W-1:0] timer, timer_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // timer counts 0..TIMEOUT-1 while open, giving exactly TIMEOUT open cycles
    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = OPEN;
                    timer_next = '0;
                end
            end
            OPEN: begin
                if (enter_i || timer == TO_W'(TIMEOUT - 1)) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    assign is_open = (state == OPEN);

endmodule

// File: rtl/carpark_access_ctrl.sv
// Two-gate access controller: reserves spaces for waiting cars, arbitrates the last
// free space round-robin and tracks occupancy from the gate sensor pulses.
module carpark_access_ctrl
    import carpark_pkg::*;
#(
    parameter int CAPACITY = CAPACITY_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int TO_W     = TO_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    carpark_access_ctrl_if.slave  bus
);

    localparam int SUM_W = CNT_W + 2;
    localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);
    localparam logic signed [SUM_W-1:0] ONE_S = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] TWO_S = SUM_W'(2);

    logic [NUM_GATES-1:0] is_open, cand, grant;
    logic [CNT_W-1:0]     count_q, count_next;
    logic                 err_q, err_next, rr_q, rr_next;
    logic signed [SUM_W-1:0] occupied, free_slots, count_sum;

    // grant decisions see only registered count and registered open gates
    always_comb begin
        cand       = ~is_open & bus.req;
        occupied   = $signed({2'b00, count_q}) + $signed({{CNT_W{1'b0}}, popcount2(is_open)});
        free_slots = CAP_S - occupied;
        grant      = '0;
        rr_next    = rr_q;
        if (cand == 2'b11) begin
            if (free_slots >= TWO_S) begin
                grant = 2'b11;
            end else if (free_slots == ONE_S) begin
                grant   = rr_q ? 2'b10 : 2'b01;
                rr_next = ~rr_q;
            end
        end else if (cand != 2'b00 && free_slots >= ONE_S) begin
            grant = cand;
        end
    end

    // enters count even without an open barrier; out-of-range results clamp and flag
    always_comb begin
        count_sum  = $signed({2'b00, count_q})
                   + $signed({{CNT_W{1'b0}}, popcount2(bus.enter)})
                   - $signed({{CNT_W{1'b0}}, popcount2(bus.exit)});
        count_next = count_sum[CNT_W-1:0];
        err_next   = err_q;
        if (count_sum > CAP_S) begin
            count_next = CNT_W'(CAPACITY);
            err_next   = 1'b1;
        end else if (count_sum < $signed(SUM_W'(0))) begin
            count_next = '0;
            err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            err_q   <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            count_q <= count_next;
            err_q   <= err_next;
            rr_q    <= rr_next;
        end
    end

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
        gate_sequencer #(
            .TIMEOUT (TIMEOUT),
            .TO_W    (TO_W)
        ) u_gate (
            .clk     (clk),
            .reset   (reset),
            .grant   (grant[g]),
            .enter_i (bus.enter[g]),
            .is_open (is_open[g])
        );
    end

    assign bus.gate_open = is_open;
    assign bus.count     = count_q;
    assign bus.full      = (count_q == CNT_W'(CAPACITY));
    assign bus.err       = err_q;

endmodule

// File: doc/carpark_access_ctrl.md
# carpark_access_ctrl

Two-gate access controller for the car park. It shares the single occupancy resource between an entry lane at gate 0 and one at gate 1, and opens a barrier only when a space can be reserved for the waiting car. The occupancy count is updated from the enter/exit pulses produced by the per-gate sensor FSMs. The block sits between those FSMs and the barrier drivers / LED display.

## Interface
- CAPACITY, 7, number of spaces; count saturates here
- CNT_W, 3, width of count; must hold CAPACITY
- TIMEOUT, 50, cycles a barrier stays open without an entry before it is withdrawn
- TO_W, 6, timer width; must hold TIMEOUT
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  2  level; car waiting at barrier of gate i
- enter  in  2  one-cycle pulse; car entered through gate i (from gate sensor FSM)
- exit  in  2  one-cycle pulse; car left through gate i
- gate_open  out  2  registered; barrier i raised
- count  out  CNT_W  registered occupancy
- full  out  1  count == CAPACITY (decoded from count register)
- err  out  1  sticky; overflow or underflow attempt since reset

## Operation
- Per-gate FSM with two states:
  - IDLE: if req[i] and granted, go to OPEN.
  - OPEN: on enter[i], go to IDLE. When the timer reaches TIMEOUT-1, go to IDLE (reservation released).
  - req[i] is ignored while the gate is OPEN.
- gate_open[i] = (state_i == OPEN).
- reserved = number of gates in OPEN (0..2).
- Gate i can be granted only when it is IDLE, req[i] is high, and count + reserved + (grants issued this cycle) < CAPACITY.
- Arbitration:
  - If both gates are grantable and two slots are free, both are granted in the same cycle.
  - If only one slot is free, round-robin pointer rr picks the winner. rr then points to the other gate.
  - rr changes only on a contested grant.
- Count update: count_next = count + popcount(enter) − popcount(exit), using CNT_W+2 signed intermediate arithmetic.
  - An enter is counted even when its gate is not OPEN (tailgating).
  - Result above CAPACITY: saturate at CAPACITY and set err.
  - Result below 0: clamp to 0 and set err.
- Enter and exit in the same cycle net out (e.g. enter[0]+exit[1] leaves count unchanged).
- An enter arriving while the gate is OPEN both increments count and drops the reservation in the same edge, so count + reserved stays consistent.
- err clears only on reset.

## Timing
- Reset (asynchronous assert):
  - Outputs: count=0, gate_open=00, err=0, full=0.
  - Internal: both FSMs in IDLE, timers=0, rr=0 (gate 0 preferred).
- Grant latency: req[i] high and grantable at edge N gives gate_open[i]=1 after edge N.
- Close latency: enter[i] sampled at edge M gives gate_open[i]=0 and count+1 after edge M.
- Timeout: gate_open[i] is high for exactly TIMEOUT cycles. After that the gate spends at least one cycle in IDLE before it can be regranted.
- The timer resets to 0 on every entry to OPEN.
- Grant decisions use registered count/reserved only. A space freed by exit at edge N is grantable from edge N+1.
- Reset asserted mid-operation closes both barriers immediately and discards count.

## Structure
- Shared package carpark_pkg:
  - gate_state_t enum {IDLE, OPEN}
  - default CAPACITY/TIMEOUT and derived widths
  - a popcount2 function
- Sub-module gate_sequencer: per-gate FSM plus timeout counter. Inputs: grant, enter_i. Outputs: is_open. Instantiated twice.
- The top level holds the arbiter, rr, count, err and full.

## Test plan
- Reset: bring count to 3, assert reset low mid-cycle -> count=0, gate_open=00, err=0 immediately, without waiting for a clock.
- Single entry: count 0, req=01 -> gate_open=01 one cycle later. Pulse enter[0] -> count=1, gate_open=00 next cycle.
- Contention at last space: count=6, rr=0, req=11 -> only gate_open[0]=1. After enter[0]: count=7, full=1, gate 1 stays closed. Then exit[1] pulse -> count=6, gate_open[1]=1 one cycle later.
- Timeout: count 0, hold req=10, no enter -> gate_open[1] high 50 cycles, low 1 cycle, high again. count stays 0.
- Simultaneous events: count=4, enter[0] and exit[1] in the same cycle -> count=4, err=0. Also enter=11 at count=6 -> count=7, err=1.
- Underflow: count=0, exit[0] pulse -> count=0, err=1 and stays 1 until reset.
